// File: rtl/button_shift_register.sv
// Push-button front end: synchronises and debounces a raw button on divider ticks,
// then shifts the debounced level into a WIDTH-bit LED register once per tick.
module button_shift_register #(
  parameter int WIDTH          = 8,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             btn_level,
  output logic             btn_press,
  output logic             shift_valid
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       q_next;

  assign btn_s = sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
    end
  end

  // A new level is accepted only after DEBOUNCE_TICKS consecutive disagreeing ticks;
  // any agreeing tick restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      if (tick) begin
        if (btn_s == btn_level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt       <= '0;
          btn_level <= btn_s;
          btn_press <= btn_s;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // The shift uses the registered level, so the flipping tick still shifts the old level.
  if (WIDTH == 1) begin : g_narrow
    assign q_next = btn_level;
  end else begin : g_wide
    assign q_next = {q[WIDTH-2:0], btn_level};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q           <= '0;
      shift_valid <= 1'b0;
    end else if (clear) begin
      q           <= '0;
      shift_valid <= 1'b0;
    end else if (tick) begin
      q           <= q_next;
      shift_valid <= 1'b1;
    end else begin
      shift_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_shift_register.sv
// Scoreboard bench: each issued tick pushes its hand-computed q; a monitor pops and
// compares whenever shift_valid is seen. Level/press/reset checks are made inline.
module tb_button_shift_register;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             btn;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic             btn_level;
  logic             btn_press;
  logic             shift_valid;

  int n_vec = 0;
  int n_err = 0;
  int press_count = 0;
  logic [WIDTH-1:0] exp_q[$];

  button_shift_register #(
    .WIDTH(WIDTH), .DEBOUNCE_TICKS(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .clear(clear),
    .q(q), .btn_level(btn_level), .btn_press(btn_press), .shift_valid(shift_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented shift against the scoreboard and counts press cycles.
  always @(posedge clk) begin
    #1;
    if (shift_valid) begin
      if (exp_q.size() == 0) begin
        check("shift_valid_unexpected", {31'd0, shift_valid}, 32'd0);
      end else begin
        check("q_on_shift", {24'd0, q}, {24'd0, exp_q.pop_front()});
      end
    end
    if (btn_press) press_count++;
  end

  // One tick every 10 clocks; the expected q is queued unless the tick is cleared.
  task automatic do_tick(input logic [WIDTH-1:0] e, input bit clr);
    repeat (9) @(negedge clk);
    if (!clr) exp_q.push_back(e);
    tick  = 1'b1;
    clear = clr;
    @(negedge clk);
    tick  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"}, {24'd0, q}, 32'd0);
    check({tag, "_level"}, {31'd0, btn_level}, 32'd0);
    check({tag, "_press"}, {31'd0, btn_press}, 32'd0);
    check({tag, "_shift_valid"}, {31'd0, shift_valid}, 32'd0);
  endtask

  logic [WIDTH-1:0] rise_seq[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [WIDTH-1:0] fall_seq[8] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [WIDTH-1:0] load_seq[6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    clear = 1'b0;
    btn   = 1'b0;
    #1;
    check_reset_outputs("reset_initial");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stable press: level rises on the 4th tick, which still shifts in 0.
    btn = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
    check("press_level_before_4th", {31'd0, btn_level}, 32'd0);
    do_tick(8'h00, 1'b0);
    check("press_level_at_4th", {31'd0, btn_level}, 32'd1);
    check("press_pulse_high", {31'd0, btn_press}, 32'd1);
    for (int i = 0; i < 8; i++) do_tick(rise_seq[i], 1'b0);
    check("press_count_after_rise", press_count, 32'd1);

    // Release: level falls on the 4th tick with no pulse, then zeros shift in.
    btn = 1'b0;
    for (int i = 0; i < 3; i++) do_tick(8'hFF, 1'b0);
    check("release_level_before_4th", {31'd0, btn_level}, 32'd1);
    do_tick(8'hFF, 1'b0);
    check("release_level_at_4th", {31'd0, btn_level}, 32'd0);
    for (int i = 0; i < 8; i++) do_tick(fall_seq[i], 1'b0);
    check("press_count_after_release", press_count, 32'd1);

    // Glitch: three disagreeing ticks, then the button returns low.
    btn = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
    btn = 1'b0;
    for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
    check("glitch_level", {31'd0, btn_level}, 32'd0);
    check("glitch_press_count", press_count, 32'd1);

    // Build q = 0x3C, then clear on a tick that also advances the debouncer.
    btn = 1'b1;
    for (int i = 0; i < 4; i++) do_tick(8'h00, 1'b0);
    check("load_level_high", {31'd0, btn_level}, 32'd1);
    btn = 1'b0;
    for (int i = 0; i < 6; i++) do_tick(load_seq[i], 1'b0);
    check("load_level_low", {31'd0, btn_level}, 32'd0);
    check("load_q_3c", {24'd0, q}, 32'h3C);
    btn = 1'b1;
    do_tick(8'h00, 1'b1);
    check("clear_q", {24'd0, q}, 32'd0);
    check("clear_shift_valid", {31'd0, shift_valid}, 32'd0);
    for (int i = 0; i < 2; i++) do_tick(8'h00, 1'b0);
    check("clear_cnt_level_after_3", {31'd0, btn_level}, 32'd0);
    do_tick(8'h00, 1'b0);
    check("clear_cnt_level_after_4", {31'd0, btn_level}, 32'd1);
    check("press_count_after_clear", press_count, 32'd3);

    // Asynchronous reset asserted mid-cycle with q and btn_level nonzero.
    do_tick(8'h01, 1'b0);
    do_tick(8'h03, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midcycle");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-debounce: partial count of 2 must be discarded.
    do_tick(8'h00, 1'b0);
    do_tick(8'h00, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
    check("rst_debounce_level_after_3", {31'd0, btn_level}, 32'd0);
    do_tick(8'h00, 1'b0);
    check("rst_debounce_level_after_4", {31'd0, btn_level}, 32'd1);
    do_tick(8'h01, 1'b0);
    check("press_count_final", press_count, 32'd4);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_shift_register.md
Name: button_shift_register

Overview:
Consumes the single-cycle tick strobe from the clock divider and a raw push-button input. It synchronises and debounces the button, counting the debounce interval in ticks. On every tick it shifts the debounced button level into a WIDTH-bit register that drives LEDs. It also emits one-cycle press and shift-update strobes for downstream logic.

Parameters:
WIDTH, 8, shift register length in bits; must be >= 1
DEBOUNCE_TICKS, 4, number of consecutive disagreeing ticks required to accept a new button level; must be >= 1
SYNC_STAGES, 2, flops in the button synchroniser chain; must be >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  single-clk-cycle strobe from the clock divider
btn  input  1  raw asynchronous push-button level, active-high
clear  input  1  synchronous clear of the shift register
q  output  WIDTH  shift register contents; q[0] is the newest bit
btn_level  output  1  debounced button level
btn_press  output  1  one-cycle pulse on debounced 0->1 transition
shift_valid  output  1  one-cycle pulse on the edge where q is updated by a tick

Behaviour:
- Reset: one clock, clk. Reset is asynchronous, active-low on rst_n. Assertion immediately clears every register: synchroniser, debounce counter, btn_level, q, btn_press, shift_valid. Release is sampled on clk.
- Synchroniser: a SYNC_STAGES-deep flop chain on btn, reset to 0. Its final stage is btn_s.
- Debounce counter: cnt, width $clog2(DEBOUNCE_TICKS+1). It changes only in cycles where tick=1 and holds otherwise.
  - Tick with btn_s == btn_level: cnt <= 0.
  - Tick with btn_s != btn_level and cnt == DEBOUNCE_TICKS-1: btn_level <= btn_s, cnt <= 0.
  - Tick with btn_s != btn_level otherwise: cnt <= cnt+1.
  - Net effect: btn_level flips on the DEBOUNCE_TICKS-th consecutive tick that sees disagreement. With DEBOUNCE_TICKS=1 it flips on the first such tick.
- btn_press is registered and is high for exactly the one clk cycle in which btn_level first reads 1. A falling transition produces no pulse.
- Shift: on a tick with clear=0, q <= {q[WIDTH-2:0], btn_level}. btn_level here is the registered, pre-update value, so the tick that flips btn_level shifts in the old level. For WIDTH=1, q <= btn_level.
- shift_valid is set on the same edge that q updates from a tick and is high for one cycle. It is 0 on all other cycles.
- clear has priority over tick for q: q <= 0, shift_valid <= 0. clear does not affect the synchroniser, cnt, btn_level or btn_press. A tick coincident with clear is still processed by the debouncer.
- tick high for N consecutive clk cycles counts as N ticks; the block does no edge detection on tick.
- Reset mid-debounce discards partial count; after release a full DEBOUNCE_TICKS of disagreement is needed.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: rst_n=0 at any time, including mid-clock -> q=0x00, btn_level=0, btn_press=0, shift_valid=0 immediately, with no clk edge needed.
- Stable press (WIDTH=8, DEBOUNCE_TICKS=4, SYNC_STAGES=2, tick every 10 clk), btn=1 held, btn_s high before first tick:
  - btn_level rises on the 4th tick.
  - btn_press is high for exactly 1 cycle.
  - q stays 0x00 through that tick; 4 ticks later q=0x0F.
  - shift_valid pulses once per tick.
- Glitch rejection: btn high across 3 ticks then low before the 4th -> btn_level stays 0, no btn_press, q stays 0x00.
- Release: from btn_level=1 and q=0xFF, drop btn -> btn_level falls on the 4th tick with no btn_press pulse. Subsequent ticks shift zeros; 8 ticks after the fall q=0x00.
- Clear coincident with tick while q=0x3C -> q=0x00, shift_valid=0 that cycle, cnt still advances. Next tick shifts normally.
- Reset mid-debounce: cnt=2 with btn held high, pulse rst_n low for 3 clk -> after release btn_level rises only after 4 further ticks, not 2.
